rand_pkt_gen: RTL and testbench

RAND_PKT_GEN -- requirements
Module: rand_pkt_gen

---
 rtl/rand_pkt_pkg.sv | 21 ++
 rtl/rand_pkt_gen.sv | 130 +++++++++++++
 tb/tb_rand_pkt_gen.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rand_pkt_pkg.sv
// Shared types and helpers for the random AXI-Stream packet generator.
package rand_pkt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_FIN
  } state_e;

  // Byte-enable mask for a beat with `rem` bytes left; full beat once rem >= 8.
  function automatic logic [7:0] keep_mask(input logic [15:0] rem);
    logic [8:0] ones;
    if (rem >= 16'd8) begin
      return 8'hFF;
    end
    ones = (9'd1 << rem[2:0]) - 9'd1;
    return ones[7:0];
  endfunction

endpackage

// File: rtl/rand_pkt_gen.sv
// Random-length packet generator: draws a length from the PRNG, then streams
// PRNG words as AXI-Stream beats, padding bytes past the packet end with zero.
module rand_pkt_gen
  import rand_pkt_pkg::*;
#(
  parameter int unsigned MIN_LEN  = 1,
  parameter int unsigned LEN_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] pkt_count,
  input  logic [63:0] rand64,
  output logic        rng_en,
  output logic [63:0] m_tdata,
  output logic [7:0]  m_tkeep,
  output logic        m_tlast,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic [15:0] len_o,
  output logic        len_valid,
  output logic        busy,
  output logic        done,
  output logic [15:0] pkts_sent
);

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] sent_q, sent_d;

  logic [15:0] len_w;
  logic        last_w;
  logic [7:0]  keep_w;
  logic        more_w;

  assign len_w  = 16'(MIN_LEN) + 16'(rand64[LEN_BITS-1:0]);
  assign last_w = (rem_q <= 16'd8);
  assign keep_w = last_w ? keep_mask(rem_q) : 8'hFF;
  // Widened so the comparison cannot wrap when the count is 16'hFFFF.
  assign more_w = ({1'b0, sent_q} + 17'd1) < {1'b0, count_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      rem_q   <= '0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      sent_q  <= sent_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    sent_d  = sent_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (pkt_count != 16'd0) begin
            count_d = pkt_count;
            sent_d  = '0;
            state_d = ST_LEN;
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_LEN: begin
        rem_d   = len_w;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        if (m_tready) begin
          if (last_w) begin
            sent_d  = sent_q + 16'd1;
            rem_d   = '0;
            state_d = more_w ? ST_LEN : ST_FIN;
          end else begin
            rem_d = rem_q - 16'd8;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    rng_en    = 1'b0;
    m_tdata   = '0;
    m_tkeep   = '0;
    m_tlast   = 1'b0;
    m_tvalid  = 1'b0;
    len_o     = '0;
    len_valid = 1'b0;
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_FIN);
    unique case (state_q)
      ST_LEN: begin
        rng_en    = 1'b1;
        len_valid = 1'b1;
        len_o     = len_w;
      end
      ST_DATA: begin
        m_tvalid = 1'b1;
        rng_en   = m_tready;
        m_tlast  = last_w;
        m_tkeep  = keep_w;
        for (int unsigned i = 0; i < 8; i++) begin
          m_tdata[8*i +: 8] = keep_w[i] ? rand64[8*i +: 8] : 8'h00;
        end
      end
      default: begin
      end
    endcase
  end

  assign pkts_sent = sent_q;

endmodule

// File: tb/tb_rand_pkt_gen.sv
// Self-checking bench for rand_pkt_gen: xoroshiro128** stimulus PRNG plus a
// packet-level scoreboard, with two extra instances for fixed-length cases.
module tb_rand_pkt_gen;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  int total = 0;
  int bad   = 0;

  logic clk;
  logic rst, start, m_tready;
  logic [15:0] pkt_count;
  logic [63:0] rand64;
  logic rng_en, m_tlast, m_tvalid, len_valid, busy, done;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic [15:0] len_o, pkts_sent;

  logic rst_b, start_b, ready_b;
  logic [15:0] cnt_b;
  logic [63:0] rand_b;
  logic b_rng, b_last, b_valid, b_lv, b_busy, b_done;
  logic [63:0] b_data;
  logic [7:0]  b_keep;
  logic [15:0] b_len, b_pkts;

  logic rst_c, start_c;
  logic [15:0] cnt_c;
  logic c_rng, c_last, c_valid, c_lv, c_busy, c_done;
  logic [63:0] c_data;
  logic [7:0]  c_keep;
  logic [15:0] c_len, c_pkts;

  rand_pkt_gen #(.MIN_LEN(1), .LEN_BITS(6)) dut (
    .clk(clk), .rst(rst), .start(start), .pkt_count(pkt_count), .rand64(rand64),
    .rng_en(rng_en), .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .len_o(len_o), .len_valid(len_valid),
    .busy(busy), .done(done), .pkts_sent(pkts_sent));

  rand_pkt_gen #(.MIN_LEN(16), .LEN_BITS(1)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .pkt_count(cnt_b), .rand64(rand_b),
    .rng_en(b_rng), .m_tdata(b_data), .m_tkeep(b_keep), .m_tlast(b_last),
    .m_tvalid(b_valid), .m_tready(ready_b), .len_o(b_len), .len_valid(b_lv),
    .busy(b_busy), .done(b_done), .pkts_sent(b_pkts));

  rand_pkt_gen #(.MIN_LEN(20), .LEN_BITS(1)) dut_c (
    .clk(clk), .rst(rst_c), .start(start_c), .pkt_count(cnt_c), .rand64(rand_b),
    .rng_en(c_rng), .m_tdata(c_data), .m_tkeep(c_keep), .m_tlast(c_last),
    .m_tvalid(c_valid), .m_tready(ready_b), .len_o(c_len), .len_valid(c_lv),
    .busy(c_busy), .done(c_done), .pkts_sent(c_pkts));

  function automatic logic [63:0] rotl(input logic [63:0] x, input int unsigned k);
    return (x << k) | (x >> (64 - k));
  endfunction

  function automatic logic [63:0] xo_out(input logic [63:0] s0);
    return rotl(s0 * 64'd5, 7) * 64'd9;
  endfunction

  function automatic logic [127:0] xo_next(input logic [63:0] s0, input logic [63:0] s1);
    logic [63:0] t;
    t = s1 ^ s0;
    return {rotl(s0, 24) ^ t ^ (t << 16), rotl(t, 37)};
  endfunction

  // Stimulus PRNG feeding the main instance; reset together with the DUT.
  logic [63:0] p_s0, p_s1;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      p_s0 <= 64'd1;
      p_s1 <= 64'd2;
    end else if (rng_en) begin
      {p_s0, p_s1} <= xo_next(p_s0, p_s1);
    end
  end
  assign rand64 = xo_out(p_s0);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: independent PRNG copy and expected packet stream.
  logic [63:0] m_s0, m_s1;
  logic [15:0] exp_len[$];
  beat_t       exp_q[$];
  int          exp_beats;

  task automatic model_reset();
    m_s0 = 64'd1;
    m_s1 = 64'd2;
    exp_len.delete();
    exp_q.delete();
  endtask

  task automatic model_run(input int n);
    logic [63:0] w;
    int          rem;
    beat_t       b;
    exp_beats = 0;
    for (int p = 0; p < n; p++) begin
      w = xo_out(m_s0);
      {m_s0, m_s1} = xo_next(m_s0, m_s1);
      rem = 1 + int'(w[5:0]);
      exp_len.push_back(16'(rem));
      while (rem > 0) begin
        w = xo_out(m_s0);
        {m_s0, m_s1} = xo_next(m_s0, m_s1);
        b.k = (rem >= 8) ? 8'hFF : 8'((1 << rem) - 1);
        for (int i = 0; i < 8; i++) begin
          b.d[8*i +: 8] = b.k[i] ? w[8*i +: 8] : 8'h00;
        end
        b.l = (rem <= 8);
        exp_q.push_back(b);
        exp_beats++;
        rem -= 8;
      end
    end
  endtask

  // Per-cycle scoreboard on the main instance.
  int          len_sum, byte_sum, rng_cnt, done_cnt, busy_cnt, valid_cnt;
  logic [15:0] last_len;
  beat_t       last_beat;
  beat_t       prev, cur;
  logic        stalled = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      cur = '{d: m_tdata, k: m_tkeep, l: m_tlast};
      if (len_valid) begin
        chk("len_gap_tvalid", {63'd0, m_tvalid}, 64'd0);
        if (exp_len.size() == 0) chk("len_unexpected", 64'd1, 64'd0);
        else chk("len_o", {48'd0, len_o}, {48'd0, exp_len.pop_front()});
        len_sum += int'(len_o);
        last_len = len_o;
      end
      if (m_tvalid) begin
        if (stalled) begin
          chk("stall_data", m_tdata, prev.d);
          chk("stall_keep", {56'd0, m_tkeep}, {56'd0, prev.k});
          chk("stall_last", {63'd0, m_tlast}, {63'd0, prev.l});
        end
        if (m_tready) begin
          if (exp_q.size() == 0) chk("beat_unexpected", 64'd1, 64'd0);
          else begin
            beat_t e;
            e = exp_q.pop_front();
            chk("tdata", m_tdata, e.d);
            chk("tkeep", {56'd0, m_tkeep}, {56'd0, e.k});
            chk("tlast", {63'd0, m_tlast}, {63'd0, e.l});
          end
          byte_sum += $countones(m_tkeep);
          last_beat = cur;
        end
      end
      stalled = m_tvalid && !m_tready;
      prev = cur;
      if (rng_en) rng_cnt++;
      if (done) done_cnt++;
      if (busy) busy_cnt++;
      if (m_tvalid) valid_cnt++;
    end
  end

  bit ready_rnd = 1'b0;
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1 m_tready = ready_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic run(input int n, input bit rnd, input bit inject);
    int          cyc;
    logic [15:0] sent_before;
    sent_before = pkts_sent;
    len_sum = 0; byte_sum = 0; rng_cnt = 0; done_cnt = 0; busy_cnt = 0; valid_cnt = 0;
    model_run(n);
    @(posedge clk);
    #1;
    ready_rnd = rnd;
    pkt_count = 16'(n);
    start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    cyc = 0;
    while (!done && cyc < 20000) begin
      if (inject && cyc == 5) begin
        start = 1'b1;
        pkt_count = 16'd7;
      end
      if (inject && cyc == 6) start = 1'b0;
      @(posedge clk);
      #2;
      cyc++;
    end
    start = 1'b0;
    chk("run_timeout", {63'd0, done}, 64'd1);
    @(posedge clk);
    #2;
    ready_rnd = 1'b0;
    chk("exp_len_left", 64'(exp_len.size()), 64'd0);
    chk("exp_beats_left", 64'(exp_q.size()), 64'd0);
    chk("done_pulses", 64'(done_cnt), 64'd1);
    chk("rng_en_count", 64'(rng_cnt), 64'(n + exp_beats));
    chk("bytes_vs_len", 64'(byte_sum), 64'(len_sum));
    chk("busy_after", {63'd0, busy}, 64'd0);
    if (n == 0) begin
      chk("zero_pkts_sent", {48'd0, pkts_sent}, {48'd0, sent_before});
      chk("zero_busy_cycles", 64'(busy_cnt), 64'd1);
      chk("zero_tvalid_cycles", 64'(valid_cnt), 64'd0);
    end else begin
      chk("pkts_sent", {48'd0, pkts_sent}, 64'(n));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int nb;
    bit seen;
    rst = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    start = 1'b0; start_b = 1'b0; start_c = 1'b0;
    pkt_count = '0; cnt_b = '0; cnt_c = '0;
    ready_b = 1'b1;
    rand_b = 64'h0123_4567_89AB_CDE0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_tvalid", {63'd0, m_tvalid}, 64'd0);
    chk("rst_rng_en", {63'd0, rng_en}, 64'd0);
    chk("rst_len_valid", {63'd0, len_valid}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_pkts_sent", {48'd0, pkts_sent}, 64'd0);
    rst = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    // Seeds 1/2 give first word 0x1680: length 1, single one-byte beat.
    run(1, 1'b0, 1'b0);
    chk("first_len", {48'd0, last_len}, 64'd1);
    chk("first_keep", {56'd0, last_beat.k}, 64'h01);
    chk("first_last", {63'd0, last_beat.l}, 64'd1);
    chk("first_data_hi", {8'd0, last_beat.d[63:8]}, 64'd0);

    run(0, 1'b0, 1'b0);
    run(5, 1'b0, 1'b0);
    run(100, 1'b1, 1'b0);
    run(3, 1'b0, 1'b1);

    // Fixed 16-byte packet: two full beats, tlast only on the second.
    @(posedge clk);
    #1 cnt_b = 16'd1; start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    nb = 0; seen = 1'b0;
    for (int cyc = 0; cyc < 30 && !seen; cyc++) begin
      if (b_lv) chk("b_len", {48'd0, b_len}, 64'd16);
      if (b_valid) begin
        nb++;
        chk("b_keep", {56'd0, b_keep}, 64'hFF);
        chk("b_data", b_data, rand_b);
        chk("b_last", {63'd0, b_last}, (nb == 2) ? 64'd1 : 64'd0);
      end
      if (b_done) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("b_beats", 64'(nb), 64'd2);
    chk("b_done_seen", {63'd0, seen}, 64'd1);
    chk("b_pkts_sent", {48'd0, b_pkts}, 64'd1);

    // 20-byte packet reset on its second beat, then restarted from scratch.
    @(posedge clk);
    #1 cnt_c = 16'd1; start_c = 1'b1;
    @(posedge clk);
    #1 start_c = 1'b0;
    nb = 0;
    for (int cyc = 0; cyc < 20 && nb < 2; cyc++) begin
      @(posedge clk);
      #1;
      if (c_valid) nb++;
    end
    chk("c_reached_beat2", 64'(nb), 64'd2);
    rst_c = 1'b1;
    #1;
    chk("c_rst_tvalid", {63'd0, c_valid}, 64'd0);
    chk("c_rst_busy", {63'd0, c_busy}, 64'd0);
    chk("c_rst_pkts", {48'd0, c_pkts}, 64'd0);
    chk("c_rst_len_valid", {63'd0, c_lv}, 64'd0);
    chk("c_rst_rng_en", {63'd0, c_rng}, 64'd0);
    @(posedge clk);
    #1 rst_c = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("c_no_resume_tvalid", {63'd0, c_valid}, 64'd0);
    chk("c_no_resume_busy", {63'd0, c_busy}, 64'd0);
    start_c = 1'b1;
    @(posedge clk);
    #1 start_c = 1'b0;
    chk("c_restart_len_valid", {63'd0, c_lv}, 64'd1);
    chk("c_restart_len", {48'd0, c_len}, 64'd20);
    chk("c_restart_tvalid", {63'd0, c_valid}, 64'd0);
    nb = 0; seen = 1'b0;
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      @(posedge clk);
      #1;
      if (c_valid) begin
        nb++;
        if (nb == 3) begin
          chk("c_last_keep", {56'd0, c_keep}, 64'h0F);
          chk("c_last_data", c_data, rand_b & 64'h0000_0000_FFFF_FFFF);
          chk("c_last_tlast", {63'd0, c_last}, 64'd1);
        end
      end
      if (c_done) seen = 1'b1;
    end
    chk("c_beats", 64'(nb), 64'd3);
    chk("c_pkts_sent", {48'd0, c_pkts}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
